// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word read/write per request, inserts WAIT
// wait states, then pulses DM_RDY. Optional address checking under DM_ALIGN_CHECK_EN.
module dm_responder #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        DM_CS,
   input  logic        DM_R,
   input  logic        DM_W,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        DM_RDY,
   output logic        DM_BUSY,
   output logic        dm_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            wr_q;
   logic            err_q;

   logic [31:0]     mem [DEPTH];

   logic            accept_c;
   logic [AW-1:0]   idx_c;
   logic            err_c;
   logic            commit_c;
   logic            commit_wr_c;
   logic            commit_err_c;
   logic [AW-1:0]   commit_idx_c;
   logic [31:0]     commit_wdata_c;

   assign idx_c = addr[AW+1:2];

`ifdef DM_ALIGN_CHECK_EN
   localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
   assign err_c = (addr[1:0] != 2'b00) || ({1'b0, addr} >= LIMIT);
`else
   // Low bits and bits above the index alias freely.
   logic unused_addr;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
   assign err_c       = 1'b0;
`endif

   // Next-state logic; commit_* describes the memory action on the edge into RESP.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      accept_c       = 1'b0;
      commit_c       = 1'b0;
      commit_wr_c    = wr_q;
      commit_err_c   = err_q;
      commit_idx_c   = idx_q;
      commit_wdata_c = wdata_q;
      case (state)
         S_IDLE: begin
            if (DM_CS && (DM_R || DM_W)) begin
               accept_c = 1'b1;
               cnt_next = CW'(WAIT);
               if (WAIT == 0) begin
                  // Zero wait states: commit straight from the live inputs.
                  state_next     = S_RESP;
                  commit_c       = 1'b1;
                  commit_wr_c    = DM_W;
                  commit_err_c   = err_c;
                  commit_idx_c   = idx_c;
                  commit_wdata_c = wdata;
               end else begin
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_next = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_next = S_RESP;
               commit_c   = 1'b1;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Request latch, counter and registered responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata   <= '0;
         DM_RDY  <= 1'b0;
         DM_BUSY <= 1'b0;
         dm_err  <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         DM_RDY  <= commit_c;
         DM_BUSY <= (state_next != S_IDLE);
         dm_err  <= commit_c && commit_err_c;
         if (accept_c) begin
            idx_q   <= idx_c;
            wdata_q <= wdata;
            wr_q    <= DM_W;
            err_q   <= err_c;
         end
         if (commit_c && !commit_wr_c)
            rdata <= commit_err_c ? 32'd0 : mem[commit_idx_c];
      end
   end

   // Storage is never reset; a reset on the commit edge discards the write.
   always_ff @(posedge clk) begin
      if (!reset && commit_c && commit_wr_c && !commit_err_c)
         mem[commit_idx_c] <= commit_wdata_c;
   end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: WAIT=2 and WAIT=0 instances against a
// transaction-level memory model (also covers DM_ALIGN_CHECK_EN builds).
module tb_dm_responder;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset, DM_R, DM_W, cs2, cs0;
   logic [31:0] addr, wdata;
   logic [31:0] rdata2, rdata0;
   logic        rdy2, rdy0, busy2, busy0, err2, err0;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mdl2 [int];
   logic [31:0] mdl0 [int];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   dm_responder #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
      .clk(clk), .reset(reset), .DM_CS(cs2), .DM_R(DM_R), .DM_W(DM_W),
      .addr(addr), .wdata(wdata), .rdata(rdata2), .DM_RDY(rdy2),
      .DM_BUSY(busy2), .dm_err(err2));

   dm_responder #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
      .clk(clk), .reset(reset), .DM_CS(cs0), .DM_R(DM_R), .DM_W(DM_W),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .DM_RDY(rdy0),
      .DM_BUSY(busy0), .dm_err(err0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit addr_err(input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // One request on instance inst (1 = WAIT 0, 0 = WAIT 2), checked end to end.
   task automatic req(input int inst, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d);
      int          wexp, lat, busy_n, i;
      bit          got, e, known;
      logic [31:0] exp_rd, obs_rd;
      logic        obs_err;
      wexp = (inst == 1) ? 0 : 2;
      e    = addr_err(a);
      i    = widx(a);
      DM_R = r; DM_W = w; addr = a; wdata = d;
      if (inst == 1) cs0 = 1'b1; else cs2 = 1'b1;
      got = 0; lat = 0; busy_n = 0;
      obs_rd = '0; obs_err = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         tick();
         if ((inst == 1) ? busy0 : busy2) busy_n++;
         if ((inst == 1) ? rdy0 : rdy2) begin
            got = 1; lat = k;
            obs_rd  = (inst == 1) ? rdata0 : rdata2;
            obs_err = (inst == 1) ? err0 : err2;
         end
      end
      cs0 = 1'b0; cs2 = 1'b0;
      n_tests++;
      if (!got || lat != wexp + 1) begin
         n_fail++;
         $display("FAIL latency inst%0d a=%h: got %0d want %0d (rdy seen %0d)", inst, a, lat, wexp + 1, got);
      end
      n_tests++;
      if (busy_n != wexp + 1) begin
         n_fail++;
         $display("FAIL busy_cycles inst%0d: got %0d want %0d", inst, busy_n, wexp + 1);
      end
      n_tests++;
      if (obs_err !== e) begin
         n_fail++;
         $display("FAIL dm_err inst%0d a=%h: got %b want %b", inst, a, obs_err, e);
      end
      known = 1;
      if (w) begin
         exp_rd = last_rd[inst];
         if (!e) begin
            if (inst == 1) mdl0[i] = d; else mdl2[i] = d;
         end
      end else if (e) begin
         exp_rd = '0;
      end else if ((inst == 1) ? mdl0.exists(i) : mdl2.exists(i)) begin
         exp_rd = (inst == 1) ? mdl0[i] : mdl2[i];
      end else begin
         exp_rd = '0; known = 0;
      end
      if (known && got) begin
         n_tests++;
         if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata inst%0d a=%h w=%b: got %h want %h", inst, a, w, obs_rd, exp_rd);
         end
         last_rd[inst] = exp_rd;
      end
      tick();
      n_tests++;
      if (((inst == 1) ? busy0 : busy2) !== 1'b0 || ((inst == 1) ? rdy0 : rdy2) !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after inst%0d: busy=%b rdy=%b want 0 0", inst,
                  (inst == 1) ? busy0 : busy2, (inst == 1) ? rdy0 : rdy2);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cs2 = 0; cs0 = 0; DM_R = 0; DM_W = 0; addr = '0; wdata = '0;
      tick(); tick();
      n_tests++;
      if ({rdata2, rdy2, busy2, err2} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_w2: got %h/%b%b%b want 0", rdata2, rdy2, busy2, err2);
      end
      n_tests++;
      if ({rdata0, rdy0, busy0, err0} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_w0: got %h/%b%b%b want 0", rdata0, rdy0, busy0, err0);
      end
      reset = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      tick();
   endtask

   task automatic test_basic();
      req(0, 0, 1, 32'h10, 32'hDEADBEEF);
      req(0, 1, 0, 32'h10, 32'h0);
   endtask

   task automatic test_wait0();
      req(1, 0, 1, 32'h4, 32'h12345678);
      req(1, 1, 0, 32'h4, 32'h0);
   endtask

   task automatic test_priority();
      req(0, 1, 1, 32'h8, 32'hA5A5A5A5);
      req(0, 1, 0, 32'h8, 32'h0);
      req(1, 1, 1, 32'h8, 32'h5A5A5A5A);
      req(1, 1, 0, 32'h8, 32'h0);
      DM_R = 0; DM_W = 0; addr = 32'h8; cs2 = 1; cs0 = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (busy2 !== 1'b0 || busy0 !== 1'b0 || rdy2 !== 1'b0 || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_strobe cyc%0d: busy=%b%b rdy=%b%b want 0", k, busy2, busy0, rdy2, rdy0);
         end
      end
      cs2 = 0; cs0 = 0;
      tick();
   endtask

   task automatic test_align();
`ifdef DM_ALIGN_CHECK_EN
      req(0, 0, 1, 32'h13, 32'h55555555);
      req(0, 1, 0, 32'h10, 32'h0);
      req(0, 1, 0, 32'h1000, 32'h0);
      req(1, 1, 0, 32'h1000, 32'h0);
`else
      req(0, 0, 1, 32'h1010, 32'hCAFEF00D);
      req(0, 1, 0, 32'h10, 32'h0);
      req(1, 0, 1, 32'h2007, 32'h0BADF00D);
      req(1, 1, 0, 32'h4, 32'h0);
`endif
   endtask

   // Continuous read request: pulses every WAIT+2 cycles, rdata stable between.
   task automatic test_back_to_back(input int inst, input logic [31:0] a);
      int          wexp, per;
      bit          exp_rdy, obs_rdy;
      logic [31:0] exp_rd, obs_rd;
      wexp = (inst == 1) ? 0 : 2;
      per  = wexp + 2;
      exp_rd = (inst == 1) ? mdl0[widx(a)] : mdl2[widx(a)];
      DM_R = 1; DM_W = 0; addr = a; wdata = '0;
      if (inst == 1) cs0 = 1; else cs2 = 1;
      for (int k = 1; k <= 3 * per; k++) begin
         tick();
         exp_rdy = ((k % per) == wexp + 1);
         obs_rdy = (inst == 1) ? rdy0 : rdy2;
         obs_rd  = (inst == 1) ? rdata0 : rdata2;
         n_tests++;
         if (obs_rdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b_rdy inst%0d cyc%0d: got %b want %b", inst, k, obs_rdy, exp_rdy);
         end
         n_tests++;
         if (obs_rd !== ((k < wexp + 1) ? last_rd[inst] : exp_rd)) begin
            n_fail++;
            $display("FAIL b2b_rdata inst%0d cyc%0d: got %h want %h", inst, k, obs_rd,
                     (k < wexp + 1) ? last_rd[inst] : exp_rd);
         end
      end
      last_rd[inst] = exp_rd;
      cs0 = 0; cs2 = 0;
      tick();
   endtask

   task automatic test_reset_abort();
      req(0, 0, 1, 32'h20, 32'h11111111);
      DM_R = 0; DM_W = 1; addr = 32'h20; wdata = 32'h22222222; cs2 = 1;
      tick();
      reset = 1; cs2 = 0; DM_W = 0;
      tick();
      n_tests++;
      if ({rdata2, rdy2, busy2, err2} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got %h/%b%b%b want 0", rdata2, rdy2, busy2, err2);
      end
      reset = 0;
      last_rd[0] = '0; last_rd[1] = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (rdy2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_rdy cyc%0d: rdy=%b busy=%b want 0 0", k, rdy2, busy2);
         end
      end
      req(0, 1, 0, 32'h20, 32'h0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      bit          w, r;
      int          inst;
      for (int k = 0; k < 16; k++) begin
         req(0, 0, 1, 32'(k * 4), $urandom);
         req(1, 0, 1, 32'(k * 4), $urandom);
      end
      for (int k = 0; k < 30; k++) begin
         inst = int'($urandom_range(0, 1));
         w    = 1'($urandom_range(0, 1));
         r    = !w || 1'($urandom_range(0, 1));
         a    = 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F003);
         req(inst, r, w, a, $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait0();
      test_priority();
      test_align();
      test_back_to_back(0, 32'h10);
      test_back_to_back(1, 32'h4);
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
